// File: rtl/rom_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port ROM.
// One read in flight; fixed ISSUE/CAPTURE/RESP sequence per transaction.
module rom_arbiter #(
  parameter int AW = 3,
  parameter int EXTRA = 4,
  localparam int DW = (2**EXTRA) * 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [AW:0]      req0_addr,
  input  logic [EXTRA-1:0] req0_extra,
  input  logic [AW:0]      cfg0_lower,
  input  logic [AW:0]      cfg0_upper,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [AW:0]      req1_addr,
  input  logic [EXTRA-1:0] req1_extra,
  input  logic [AW:0]      cfg1_lower,
  input  logic [AW:0]      cfg1_upper,
  output logic             req1_ready,
  output logic             rsp0_valid,
  output logic [DW-1:0]    rsp0_data,
  output logic             rsp0_error,
  output logic             rsp1_valid,
  output logic [DW-1:0]    rsp1_data,
  output logic             rsp1_error,
  output logic [AW:0]      mem_addr,
  output logic [EXTRA-1:0] mem_extra,
  output logic [AW:0]      mem_lower_bound,
  output logic [AW:0]      mem_upper_bound,
  input  logic [DW-1:0]    mem_data,
  input  logic             mem_error,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    RESP
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_last;
  logic             r_owner;
  logic [AW:0]      r_mem_addr;
  logic [EXTRA-1:0] r_mem_extra;
  logic [AW:0]      r_mem_lower;
  logic [AW:0]      r_mem_upper;
  logic [DW-1:0]    r_rsp0_data;
  logic             r_rsp0_err;
  logic [DW-1:0]    r_rsp1_data;
  logic             r_rsp1_err;

  logic             w_gnt_valid;
  logic             w_gnt;
  logic             w_acc;
  logic [AW:0]      w_sel_addr;
  logic [EXTRA-1:0] w_sel_extra;
  logic [AW:0]      w_sel_lower;
  logic [AW:0]      w_sel_upper;

  always_comb begin
    w_next      = r_state;
    w_gnt_valid = 1'b0;
    w_gnt       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (req0_valid && req1_valid) begin
          w_gnt_valid = 1'b1;
          w_gnt       = ~r_last;
        end else if (req0_valid) begin
          w_gnt_valid = 1'b1;
          w_gnt       = 1'b0;
        end else if (req1_valid) begin
          w_gnt_valid = 1'b1;
          w_gnt       = 1'b1;
        end
        if (w_gnt_valid) w_next = ISSUE;
      end
      ISSUE:   w_next = CAPTURE;
      CAPTURE: w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Reset masks handshakes so nothing is accepted or reported that cycle
  assign w_acc      = w_gnt_valid && !reset;
  assign req0_ready = w_acc && !w_gnt;
  assign req1_ready = w_acc && w_gnt;

  assign rsp0_valid = (r_state == RESP) && !r_owner && !reset;
  assign rsp1_valid = (r_state == RESP) && r_owner && !reset;
  assign busy       = (r_state != IDLE);

  assign w_sel_addr  = w_gnt ? req1_addr  : req0_addr;
  assign w_sel_extra = w_gnt ? req1_extra : req0_extra;
  assign w_sel_lower = w_gnt ? cfg1_lower : cfg0_lower;
  assign w_sel_upper = w_gnt ? cfg1_upper : cfg0_upper;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_last      <= 1'b1;
      r_owner     <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_extra <= '0;
      r_mem_lower <= '0;
      r_mem_upper <= '1;
      r_rsp0_data <= '0;
      r_rsp0_err  <= 1'b0;
      r_rsp1_data <= '0;
      r_rsp1_err  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_gnt_valid) begin
        r_last      <= w_gnt;
        r_owner     <= w_gnt;
        r_mem_addr  <= w_sel_addr;
        r_mem_extra <= w_sel_extra;
        r_mem_lower <= w_sel_lower;
        r_mem_upper <= w_sel_upper;
      end
      if (r_state == CAPTURE) begin
        if (r_owner) begin
          r_rsp1_data <= mem_data;
          r_rsp1_err  <= mem_error;
        end else begin
          r_rsp0_data <= mem_data;
          r_rsp0_err  <= mem_error;
        end
      end
    end
  end

  assign mem_addr        = r_mem_addr;
  assign mem_extra       = r_mem_extra;
  assign mem_lower_bound = r_mem_lower;
  assign mem_upper_bound = r_mem_upper;
  assign rsp0_data       = r_rsp0_data;
  assign rsp0_error      = r_rsp0_err;
  assign rsp1_data       = r_rsp1_data;
  assign rsp1_error      = r_rsp1_err;

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter with a behavioural ROM and a
// response scoreboard filled at accept time, drained at rsp pulses.
module tb_rom_arbiter;

  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0_valid, req1_valid;
  logic [3:0]    req0_addr, req1_addr;
  logic [3:0]    req0_extra, req1_extra;
  logic [3:0]    cfg0_lower, cfg0_upper;
  logic [3:0]    cfg1_lower, cfg1_upper;
  logic          req0_ready, req1_ready;
  logic          rsp0_valid, rsp1_valid;
  logic [DW-1:0] rsp0_data, rsp1_data;
  logic          rsp0_error, rsp1_error;
  logic [3:0]    mem_addr, mem_extra;
  logic [3:0]    mem_lower_bound, mem_upper_bound;
  logic [DW-1:0] mem_data;
  logic          mem_error;
  logic          busy;

  typedef struct {
    int            idx;
    logic [DW-1:0] data;
    logic          err;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  int   grants[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   r1_cnt = 0;

  rom_arbiter #(.AW(3), .EXTRA(4)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_addr(req0_addr),
    .req0_extra(req0_extra), .cfg0_lower(cfg0_lower),
    .cfg0_upper(cfg0_upper), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr),
    .req1_extra(req1_extra), .cfg1_lower(cfg1_lower),
    .cfg1_upper(cfg1_upper), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
    .rsp0_error(rsp0_error),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
    .rsp1_error(rsp1_error),
    .mem_addr(mem_addr), .mem_extra(mem_extra),
    .mem_lower_bound(mem_lower_bound),
    .mem_upper_bound(mem_upper_bound),
    .mem_data(mem_data), .mem_error(mem_error),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rom_word(
    input logic [3:0] a, input logic [3:0] e);
    logic [31:0] w;
    w = {16'hD00D, 4'h0, a, 4'h0, e};
    return {4{w}};
  endfunction

  function automatic logic win_err(
    input logic [3:0] a, input logic [3:0] lo,
    input logic [3:0] hi);
    return (a < lo) || (a > hi);
  endfunction

  // ROM: registered read, flags addresses outside the bounds
  always @(posedge clk) begin
    mem_data  <= rom_word(mem_addr, mem_extra);
    mem_error <= win_err(mem_addr, mem_lower_bound,
                         mem_upper_bound);
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h, expected %0h",
             tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (req0_ready && req1_ready)
      chk("ready_onehot", 1'b1, 1'b0);
    if (req0_valid && req0_ready) begin
      sb.push_back('{0, rom_word(req0_addr, req0_extra),
        win_err(req0_addr, cfg0_lower, cfg0_upper), cyc});
      grants.push_back(0);
    end
    if (req1_valid && req1_ready) begin
      sb.push_back('{1, rom_word(req1_addr, req1_extra),
        win_err(req1_addr, cfg1_lower, cfg1_upper), cyc});
      grants.push_back(1);
    end
    if (rsp1_valid) r1_cnt++;
    if (rsp0_valid || rsp1_valid) begin
      chk("rsp_onehot", rsp0_valid && rsp1_valid, 1'b0);
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 1'b1, 1'b0);
      end else begin
        e = sb.pop_front();
        chk("rsp_idx", rsp1_valid ? 1 : 0, e.idx);
        chk("rsp_data", rsp1_valid ? rsp1_data : rsp0_data,
            e.data);
        chk("rsp_err", rsp1_valid ? rsp1_error : rsp0_error,
            e.err);
        chk("rsp_latency", cyc - e.cyc, 3);
      end
    end
  end

  task automatic set_req(input int n, input logic [3:0] a,
                         input logic [3:0] e,
                         input logic [3:0] lo,
                         input logic [3:0] hi);
    if (n == 0) begin
      req0_addr = a; req0_extra = e;
      cfg0_lower = lo; cfg0_upper = hi;
      req0_valid = 1'b1;
    end else begin
      req1_addr = a; req1_extra = e;
      cfg1_lower = lo; cfg1_upper = hi;
      req1_valid = 1'b1;
    end
  endtask

  task automatic wait_acc(input int n);
    bit got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = (n == 0) ? req0_ready : req1_ready;
    end
    if (!got) chk("accept_timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
    if (n == 0) req0_valid = 1'b0;
    else        req1_valid = 1'b0;
  endtask

  task automatic hold_both(input int nacc, input bit keep);
    int  got = 0;
    bit  d0, d1;
    for (int k = 0; k < 200 && got < nacc; k++) begin
      @(negedge clk);
      d0 = req0_valid && req0_ready;
      d1 = req1_valid && req1_ready;
      if (d0 || d1) got++;
      @(posedge clk); #1;
      if (got == nacc) begin
        req0_valid = 1'b0; req1_valid = 1'b0;
      end else if (!keep) begin
        if (d0) req0_valid = 1'b0;
        if (d1) req1_valid = 1'b0;
      end
    end
    chk("hold_both_accepts", got, nacc);
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit done = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      done = (sb.size() == 0) && !busy;
    end
    chk("drain_timeout", done, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_rsp0v"}, rsp0_valid, 1'b0);
    chk({tag, "_rsp1v"}, rsp1_valid, 1'b0);
    chk({tag, "_rsp0d"}, rsp0_data, '0);
    chk({tag, "_rsp1d"}, rsp1_data, '0);
    chk({tag, "_rsp0e"}, rsp0_error, 1'b0);
    chk({tag, "_rsp1e"}, rsp1_error, 1'b0);
    chk({tag, "_maddr"}, mem_addr, 4'h0);
    chk({tag, "_mext"}, mem_extra, 4'h0);
    chk({tag, "_mlo"}, mem_lower_bound, 4'h0);
    chk({tag, "_mhi"}, mem_upper_bound, 4'hF);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    sb.delete();
    grants.delete();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req0_valid = 0; req1_valid = 0;
    req0_addr = 0; req1_addr = 0;
    req0_extra = 0; req1_extra = 0;
    cfg0_lower = 0; cfg0_upper = 4'hF;
    cfg1_lower = 0; cfg1_upper = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("por");
    reset = 1'b0;

    set_req(0, 4'h2, 4'h0, 4'h0, 4'hF);
    wait_acc(0);
    wait_drain();
    chk("single_data", rsp0_data, rom_word(4'h2, 4'h0));
    chk("single_err", rsp0_error, 1'b0);
    chk("single_no_rsp1", r1_cnt, 0);

    pulse_reset();
    set_req(0, 4'h5, 4'h3, 4'h0, 4'hF);
    set_req(1, 4'h9, 4'h1, 4'h0, 4'hF);
    hold_both(2, 1'b0);
    wait_drain();
    chk("simul_first", grants[0], 0);
    chk("simul_second", grants[1], 1);
    chk("simul_d1", rsp1_data, rom_word(4'h9, 4'h1));

    grants.delete();
    set_req(0, 4'h5, 4'h3, 4'h0, 4'hF);
    set_req(1, 4'hA, 4'h2, 4'h0, 4'hF);
    hold_both(6, 1'b1);
    wait_drain();
    chk("fair_count", grants.size(), 6);
    for (int i = 0; i < 6 && i < grants.size(); i++)
      chk($sformatf("fair_grant%0d", i), grants[i], i % 2);

    set_req(1, 4'hE, 4'h2, 4'h0, 4'h7);
    wait_acc(1);
    chk("win_lo", mem_lower_bound, 4'h0);
    chk("win_hi", mem_upper_bound, 4'h7);
    chk("win_addr", mem_addr, 4'hE);
    wait_drain();
    chk("win_err", rsp1_error, 1'b1);
    chk("hold_rsp0_data", rsp0_data, rom_word(4'h5, 4'h3));
    chk("hold_rsp0_err", rsp0_error, 1'b0);
    chk("idle_mem_hold", mem_addr, 4'hE);

    set_req(0, 4'h3, 4'h1, 4'h0, 4'hF);
    wait_acc(0);
    @(posedge clk); #1;
    chk("mid_busy", busy, 1'b1);
    reset = 1'b1;
    sb.delete();
    set_req(1, 4'h4, 4'h0, 4'h0, 4'hF);
    #1;
    chk("mid_ready1", req1_ready, 1'b0);
    chk("mid_rsp0v", rsp0_valid, 1'b0);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    reset = 1'b0;
    check_reset_vals("mid");
    repeat (6) @(posedge clk);
    #1;
    chk("mid_quiet", busy, 1'b0);
    set_req(0, 4'h3, 4'h1, 4'h0, 4'hF);
    wait_acc(0);
    wait_drain();
    chk("post_rst_data", rsp0_data, rom_word(4'h3, 4'h1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
